// File: rtl/julia_pixel_sched_pkg.sv
// Shared types and constants for the Julia pixel scheduler.
// Fixed-point values are signed 32-bit in SCALE units.
package julia_pixel_sched_pkg;

  typedef logic signed [31:0] fix_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int SCALE_DEF = 1024;

  function automatic longint esc_r2(input int s);
    return 4 * longint'(s) * longint'(s);
  endfunction

  function automatic longint esc_abs(input int s);
    return 2 * longint'(s);
  endfunction

  localparam longint ESC_R2  = esc_r2(SCALE_DEF);
  localparam longint ESC_ABS = esc_abs(SCALE_DEF);

endpackage

// File: rtl/julia_escape_chk.sv
// Combinational escape decision on one datapath result.
// res is in SCALE^2 units; a negative res means it overflowed.
module julia_escape_chk
  import julia_pixel_sched_pkg::*;
#(
  parameter int SCALE = SCALE_DEF
) (
  input  logic signed [31:0] wx,
  input  logic signed [31:0] wy,
  input  logic signed [31:0] res,
  output logic               escape
);

  localparam longint R2 = esc_r2(SCALE);
  localparam longint AB = esc_abs(SCALE);

  longint wx_l;
  longint wy_l;
  longint res_l;

  assign wx_l  = longint'(wx);
  assign wy_l  = longint'(wy);
  assign res_l = longint'(res);

  always_comb begin
    escape = 1'b0;
    if (res_l > R2)  escape = 1'b1;
    if (res_l < 0)   escape = 1'b1;
    if (wx_l > AB)   escape = 1'b1;
    if (wx_l < -AB)  escape = 1'b1;
    if (wy_l > AB)   escape = 1'b1;
    if (wy_l < -AB)  escape = 1'b1;
  end

endmodule

// File: rtl/julia_pixel_sched.sv
// Per-pixel Julia iteration controller driving a 1-cycle step datapath.
// Define JULIA_STATS_EN to add stat_pixels / stat_steps counters.
module julia_pixel_sched
  import julia_pixel_sched_pkg::*;
#(
  parameter int SCALE  = SCALE_DEF,
  parameter int ITER_W = 8,
  parameter int TAG_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic signed [31:0]       pix_x,
  input  logic signed [31:0]       pix_y,
  input  logic [TAG_W-1:0]         pix_tag,
  input  logic signed [31:0]       cfg_cr,
  input  logic signed [31:0]       cfg_ci,
  input  logic [ITER_W-1:0]        cfg_max_iter,
  output logic                     step_en,
  output logic signed [31:0]       step_x,
  output logic signed [31:0]       step_y,
  output logic signed [31:0]       step_cr,
  output logic signed [31:0]       step_ci,
  input  logic                     step_end,
  input  logic signed [31:0]       step_wx,
  input  logic signed [31:0]       step_wy,
  input  logic signed [31:0]       step_res,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ITER_W-1:0]        res_iter,
  output logic                     res_escaped,
  output logic [TAG_W-1:0]         res_tag
`ifdef JULIA_STATS_EN
  ,
  output logic [31:0]              stat_pixels,
  output logic [31:0]              stat_steps
`endif
);

  state_t state;
  state_t state_n;

  fix_t              wx_q;
  fix_t              wy_q;
  fix_t              r_q;
  logic [ITER_W-1:0] cnt;
  logic [ITER_W-1:0] max_q;
  logic              esc_q;
  logic              escape;
  logic              accept;
  logic              cap;
  logic              hs;
  logic              at_lim;

  julia_escape_chk #(
    .SCALE (SCALE)
  ) u_esc (
    .wx     (wx_q),
    .wy     (wy_q),
    .res    (r_q),
    .escape (escape)
  );

  assign accept = (state == S_IDLE) && pix_valid;
  assign cap    = (state == S_WAIT) && step_end;
  assign hs     = (state == S_DONE) && res_ready;
  assign at_lim = (cnt == max_q);

  assign pix_ready   = (state == S_IDLE);
  assign step_en     = (state == S_ISSUE) || (state == S_WAIT);
  assign res_valid   = (state == S_DONE);
  assign res_iter    = cnt;
  assign res_escaped = esc_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (pix_valid)
          state_n = (cfg_max_iter == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (step_end) state_n = S_CHECK;
      end
      S_CHECK: begin
        if (escape || at_lim) state_n = S_DONE;
        else                  state_n = S_ISSUE;
      end
      S_DONE: begin
        if (res_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Operands only move on accept or on the CHECK->ISSUE hop.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_x  <= '0;
      step_y  <= '0;
      step_cr <= '0;
      step_ci <= '0;
      max_q   <= '0;
      res_tag <= '0;
      cnt     <= '0;
      esc_q   <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      r_q     <= '0;
    end else begin
      if (accept) begin
        step_x  <= pix_x;
        step_y  <= pix_y;
        step_cr <= cfg_cr;
        step_ci <= cfg_ci;
        max_q   <= cfg_max_iter;
        res_tag <= pix_tag;
        cnt     <= '0;
        esc_q   <= 1'b0;
      end
      if (cap) begin
        wx_q <= step_wx;
        wy_q <= step_wy;
        r_q  <= step_res;
        cnt  <= cnt + 1'b1;
      end
      if (state == S_CHECK) begin
        if (escape) begin
          esc_q <= 1'b1;
        end else if (!at_lim) begin
          step_x <= wx_q;
          step_y <= wy_q;
        end
      end
    end
  end

`ifdef JULIA_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pixels <= '0;
      stat_steps  <= '0;
    end else begin
      if (hs && (stat_pixels != '1))
        stat_pixels <= stat_pixels + 32'd1;
      if (cap && (stat_steps != '1))
        stat_steps <= stat_steps + 32'd1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_julia_pixel_sched.sv
// Bench for julia_pixel_sched with a behavioural step datapath
// and an orbit-level model of the expected iteration results.
module tb_julia_pixel_sched;

  localparam int SCALE  = 1024;
  localparam int ITER_W = 8;
  localparam int TAG_W  = 19;

  logic                clk = 1'b0;
  logic                rst;
  logic                pix_valid;
  logic                pix_ready;
  logic signed [31:0]  pix_x, pix_y;
  logic [TAG_W-1:0]    pix_tag;
  logic signed [31:0]  cfg_cr, cfg_ci;
  logic [ITER_W-1:0]   cfg_max_iter;
  logic                step_en;
  logic signed [31:0]  step_x, step_y, step_cr, step_ci;
  logic                step_end;
  logic signed [31:0]  step_wx, step_wy, step_res;
  logic                res_valid;
  logic                res_ready;
  logic [ITER_W-1:0]   res_iter;
  logic                res_escaped;
  logic [TAG_W-1:0]    res_tag;
`ifdef JULIA_STATS_EN
  logic [31:0]         stat_pixels, stat_steps;
  int                  exp_pix, exp_steps;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  julia_pixel_sched #(
    .SCALE (SCALE), .ITER_W (ITER_W), .TAG_W (TAG_W)
  ) dut (
    .clk (clk), .rst (rst),
    .pix_valid (pix_valid), .pix_ready (pix_ready),
    .pix_x (pix_x), .pix_y (pix_y), .pix_tag (pix_tag),
    .cfg_cr (cfg_cr), .cfg_ci (cfg_ci),
    .cfg_max_iter (cfg_max_iter),
    .step_en (step_en),
    .step_x (step_x), .step_y (step_y),
    .step_cr (step_cr), .step_ci (step_ci),
    .step_end (step_end),
    .step_wx (step_wx), .step_wy (step_wy),
    .step_res (step_res),
    .res_valid (res_valid), .res_ready (res_ready),
    .res_iter (res_iter), .res_escaped (res_escaped),
    .res_tag (res_tag)
`ifdef JULIA_STATS_EN
    , .stat_pixels (stat_pixels), .stat_steps (stat_steps)
`endif
  );

  task automatic chk(input string nm,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One Julia step: x'=x^2-y^2+cr, y'=2xy+ci, res=wx^2+wy^2 (wraps).
  function automatic void dp(input logic signed [31:0] x, y, cr, ci,
                             output logic signed [31:0] wx, wy, r);
    longint lx, ly, a, b, t;
    lx = longint'(x);
    ly = longint'(y);
    a  = (lx * lx - ly * ly) / SCALE + longint'(cr);
    b  = (2 * lx * ly) / SCALE + longint'(ci);
    wx = a[31:0];
    wy = b[31:0];
    t  = longint'(wx) * longint'(wx) + longint'(wy) * longint'(wy);
    r  = t[31:0];
  endfunction

  // Orbit model: how many steps until escape or the limit.
  function automatic void jmodel(input logic signed [31:0] x0, y0, cr, ci,
                                 input int mx, output int it, output bit esc);
    logic signed [31:0] x, y, wx, wy, r;
    longint lim;
    x = x0; y = y0; it = 0; esc = 0;
    lim = 2 * SCALE;
    for (int k = 0; k < mx; k++) begin
      dp(x, y, cr, ci, wx, wy, r);
      it++;
      if (longint'(r) > 4 * longint'(SCALE) * SCALE || r < 0 ||
          longint'(wx) > lim || longint'(wx) < -lim ||
          longint'(wy) > lim || longint'(wy) < -lim) begin
        esc = 1;
        return;
      end
      x = wx; y = wy;
    end
  endfunction

  // Behavioural datapath: registered, end flag low while disabled.
  always @(posedge clk) begin : dpm
    logic signed [31:0] a, b, c;
    if (!step_en) begin
      step_end <= 1'b0;
    end else begin
      dp(step_x, step_y, step_cr, step_ci, a, b, c);
      step_wx  <= a;
      step_wy  <= b;
      step_res <= c;
      step_end <= 1'b1;
    end
  end

  // Per-cycle checks: operand stability under step_en, no accept in DONE.
  logic signed [31:0] px, py, pcr, pci;
  logic pen = 1'b0;
  always @(negedge clk) begin
    if (!rst && step_en && pen)
      chk("op_stable",
          ({step_x, step_y, step_cr, step_ci} == {px, py, pcr, pci}), 1);
    if (!rst && res_valid)
      chk("ready_in_done", pix_ready, 0);
    pen <= step_en && !rst;
    px  <= step_x;
    py  <= step_y;
    pcr <= step_cr;
    pci <= step_ci;
  end

  task automatic run_pixel(input string nm,
                           input logic signed [31:0] x, y, cr, ci,
                           input int mx, input int tag,
                           input int e_it, input bit e_esc, input int bp);
    int m_it, lat, en_n, g;
    bit m_esc;
    logic [TAG_W-1:0] t;
    jmodel(x, y, cr, ci, mx, m_it, m_esc);
    chk({nm, "_model_iter"}, m_it, e_it);
    chk({nm, "_model_esc"}, m_esc, e_esc);
    t = tag[TAG_W-1:0];
    @(negedge clk);
    pix_x = x; pix_y = y; cfg_cr = cr; cfg_ci = ci;
    pix_tag = t; cfg_max_iter = mx[ITER_W-1:0];
    pix_valid = 1'b1;
    g = 0;
    while (!pix_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!pix_ready) begin
      chk({nm, "_accept"}, 0, 1);
      pix_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 pix_valid = 1'b0;
    lat = 0; en_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (step_en) en_n++;
    end while (!res_valid && lat < 5000);
    chk({nm, "_res_valid"}, res_valid, 1);
    if (!res_valid) return;
    chk({nm, "_latency"}, lat, 3 * m_it + 1);
    chk({nm, "_en_cycles"}, en_n, 2 * m_it);
    chk({nm, "_iter"}, res_iter, m_it);
    chk({nm, "_escaped"}, res_escaped, m_esc);
    chk({nm, "_tag"}, res_tag, t);
    if (bp > 0) begin
      pix_valid = 1'b1;
      pix_tag = t ^ 1;
      repeat (bp) begin
        @(negedge clk);
        chk({nm, "_bp_hold"},
            {res_valid, pix_ready, res_escaped, res_iter},
            {1'b1, 1'b0, m_esc, m_it[ITER_W-1:0]});
        chk({nm, "_bp_tag"}, res_tag, t);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_after_hs"}, {res_valid, pix_ready}, 2'b01);
`ifdef JULIA_STATS_EN
    exp_pix++;
    exp_steps += m_it;
    chk({nm, "_stat_pix"}, stat_pixels, exp_pix);
    chk({nm, "_stat_steps"}, stat_steps, exp_steps);
`endif
  endtask

  initial begin
    int vcnt;
    rst = 1'b1;
    pix_valid = 1'b0; res_ready = 1'b0;
    pix_x = '0; pix_y = '0; pix_tag = '0;
    cfg_cr = '0; cfg_ci = '0; cfg_max_iter = '0;
`ifdef JULIA_STATS_EN
    exp_pix = 0; exp_steps = 0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", pix_ready, 1);
    chk("rst_en", step_en, 0);
    chk("rst_ops", ({step_x, step_y, step_cr, step_ci} == 128'd0), 1);
    chk("rst_res", {res_valid, res_escaped, res_iter, res_tag}, 0);

    run_pixel("zero", 0, 0, 0, 0, 255, 19'h1_2345, 255, 0, 0);
    run_pixel("big",  3072, 0, 0, 0, 255, 19'h7_0001, 1, 1, 0);
    run_pixel("unit", 1024, 0, 0, 0, 10, 19'h0_00aa, 10, 0, 0);
    run_pixel("maxz", 5000, -7, 3, 4, 0, 19'h5_5555, 0, 0, 0);
    run_pixel("c512", 0, 0, 512, 0, 50, 19'h0_0512, 5, 1, 0);
    run_pixel("cneg", 0, 0, -1024, 0, 20, 19'h2_0000, 20, 0, 0);
    run_pixel("ci_bp", 0, 0, 0, 3000, 255, 19'h3_0bb0, 1, 1, 10);
    run_pixel("ovf", 0, 0, 50000, 0, 5, 19'h4_0004, 1, 1, 0);

    // Reset during the second WAIT.
    @(negedge clk);
    pix_x = 1024; pix_y = 0; cfg_cr = 0; cfg_ci = 0;
    cfg_max_iter = 8'd10; pix_tag = 19'h1; pix_valid = 1'b1;
    @(posedge clk);
    #1 pix_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wait2_en", step_en, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", {step_en, pix_ready, res_valid}, 3'b010);
`ifdef JULIA_STATS_EN
    exp_pix = 0; exp_steps = 0;
    chk("mid_rst_stats", {stat_pixels, stat_steps}, 0);
`endif
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) vcnt++;
    end
    chk("mid_rst_no_valid", vcnt, 0);

    run_pixel("after", 1024, 0, 0, 0, 3, 19'h6_0606, 3, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
